// File: rtl/batalha_pkg.sv
// Shared types, LED codes and cell helpers for the battleship controller.
package batalha_pkg;

    typedef enum logic [1:0] {
        DESLIGADO      = 2'd0,
        POSICIONAMENTO = 2'd1,
        ATAQUE         = 2'd2,
        FIM            = 2'd3
    } estado_t;

    localparam logic [1:0] LED_APAGADO  = 2'b00;
    localparam logic [1:0] LED_AGUA     = 2'b01;
    localparam logic [1:0] LED_ACERTO   = 2'b10;
    localparam logic [1:0] LED_INVALIDO = 2'b11;

    // Largest board is 8x8; popcount takes a zero-extended vector of this width.
    localparam int MAX_CEL = 64;

    function automatic int unsigned indice_celula(input int unsigned coluna,
                                                  input int unsigned linha,
                                                  input int unsigned linhas);
        return (coluna - 1) * linhas + (linha - 1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_CEL-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_CEL; i++)
            n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic sinal,
    output logic pulso
);

    logic anterior;

    always_ff @(posedge clk) begin
        if (!rst_n) anterior <= 1'b0;
        else        anterior <= sinal;
    end

    assign pulso = sinal & ~anterior;

endmodule

// File: rtl/controlador_batalha.sv
// Battleship game controller: placement, save, attacks, counters, end of game.
// Optional ATAQUE_REPETIDO_EN: keep a miss mask and flag any repeated shot as invalid.
module controlador_batalha
    import batalha_pkg::*;
#(
    parameter int COLUNAS = 5,
    parameter int LINHAS  = 7,
    parameter int W_TENT  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ligado,
    input  logic                                 modo,
    input  logic                                 salvar_jogo,
    input  logic                                 confirmar_ataque,
    input  logic [$clog2(COLUNAS+1)-1:0]         ataque_coluna,
    input  logic [$clog2(LINHAS+1)-1:0]          ataque_linha,
    input  logic [COLUNAS*LINHAS-1:0]            posicionamento,
    output logic [COLUNAS*LINHAS-1:0]            saida,
    output logic [1:0]                           ledRGB,
    output logic                                 jogo_salvo,
    output logic                                 fim_de_jogo,
    output logic [$clog2(COLUNAS*LINHAS+1)-1:0]  acertos,
    output logic [W_TENT-1:0]                    tentativas
);

    localparam int N  = COLUNAS * LINHAS;
    localparam int AW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    estado_t          estado, estado_nxt;
    logic [N-1:0]     tabuleiro, tabuleiro_nxt;
    logic [N-1:0]     acerto_q, acerto_nxt;     // 0 = cell already hit
    logic [AW-1:0]    navios, navios_nxt;
    logic [AW-1:0]    acertos_nxt, navios_salvar;
    logic [W_TENT-1:0] tent_nxt, tent_inc;
    logic             salvo_nxt, fim_nxt;
    logic [1:0]       led_nxt;
    logic [N-1:0]     saida_nxt;
`ifdef ATAQUE_REPETIDO_EN
    logic [N-1:0]     agua_q, agua_nxt;         // 0 = water cell already shot
`endif

    logic             pulso_salvar, pulso_ataque;
    logic             salvar_ok, ataque_ok, coord_ok;
    logic [IW-1:0]    idx;
    logic [MAX_CEL-1:0] navios_vec;

    detector_borda u_borda_salvar (
        .clk   (clk),
        .rst_n (rst_n),
        .sinal (salvar_jogo),
        .pulso (pulso_salvar)
    );

    detector_borda u_borda_ataque (
        .clk   (clk),
        .rst_n (rst_n),
        .sinal (confirmar_ataque),
        .pulso (pulso_ataque)
    );

    always_comb begin
        navios_vec        = '0;
        navios_vec[N-1:0] = ~posicionamento;
    end

    assign navios_salvar = AW'(popcount(navios_vec));
    assign coord_ok = (ataque_coluna != '0) && (int'(ataque_coluna) <= COLUNAS) &&
                      (ataque_linha  != '0) && (int'(ataque_linha)  <= LINHAS);
    assign idx      = IW'(indice_celula(32'(ataque_coluna), 32'(ataque_linha), LINHAS));
    assign tent_inc = (tentativas == '1) ? tentativas : tentativas + W_TENT'(1);

    // Save and attack are only legal in mutually exclusive states, so they never collide.
    assign salvar_ok = (estado == POSICIONAMENTO) && !modo && pulso_salvar && (navios_salvar != '0);
    assign ataque_ok = (estado == ATAQUE) && modo && pulso_ataque && jogo_salvo;

    always_comb begin
        estado_nxt    = estado;
        tabuleiro_nxt = tabuleiro;
        acerto_nxt    = acerto_q;
        navios_nxt    = navios;
        acertos_nxt   = acertos;
        tent_nxt      = tentativas;
        salvo_nxt     = jogo_salvo;
        fim_nxt       = fim_de_jogo;
        led_nxt       = ledRGB;
        saida_nxt     = saida;
`ifdef ATAQUE_REPETIDO_EN
        agua_nxt      = agua_q;
`endif

        if (salvar_ok) begin
            tabuleiro_nxt = posicionamento;
            navios_nxt    = navios_salvar;
            acerto_nxt    = '1;
            acertos_nxt   = '0;
            tent_nxt      = '0;
            fim_nxt       = 1'b0;
            salvo_nxt     = 1'b1;
`ifdef ATAQUE_REPETIDO_EN
            agua_nxt      = '1;
`endif
        end

        if (ataque_ok) begin
            if (!coord_ok) begin
                led_nxt = LED_INVALIDO;
`ifdef ATAQUE_REPETIDO_EN
            end else if (!acerto_q[idx] || !agua_q[idx]) begin
                led_nxt = LED_INVALIDO;
            end else if (!tabuleiro[idx]) begin
                led_nxt         = LED_ACERTO;
                acerto_nxt[idx] = 1'b0;
                acertos_nxt     = acertos + AW'(1);
                tent_nxt        = tent_inc;
            end else begin
                led_nxt       = LED_AGUA;
                agua_nxt[idx] = 1'b0;
                tent_nxt      = tent_inc;
            end
`else
            end else if (!tabuleiro[idx]) begin
                led_nxt  = LED_ACERTO;
                tent_nxt = tent_inc;
                if (acerto_q[idx]) begin
                    acerto_nxt[idx] = 1'b0;
                    acertos_nxt     = acertos + AW'(1);
                end
            end else begin
                led_nxt  = LED_AGUA;
                tent_nxt = tent_inc;
            end
`endif
            if (acertos_nxt == navios)
                fim_nxt = 1'b1;
        end

        case (estado)
            DESLIGADO:      estado_nxt = POSICIONAMENTO;
            POSICIONAMENTO: if (modo) estado_nxt = ATAQUE;
            ATAQUE: begin
                if (!modo)        estado_nxt = POSICIONAMENTO;
                else if (fim_nxt) estado_nxt = FIM;
            end
            FIM:            if (!modo) estado_nxt = POSICIONAMENTO;
            default:        estado_nxt = DESLIGADO;
        endcase

        // Display follows the state being entered so it lines up with the state register.
        case (estado_nxt)
            POSICIONAMENTO: begin
                led_nxt   = LED_APAGADO;
                saida_nxt = posicionamento;
            end
            ATAQUE:         saida_nxt = acerto_nxt;
            FIM: begin
                led_nxt   = LED_ACERTO;
                saida_nxt = acerto_nxt;
            end
            default: begin
                led_nxt   = LED_APAGADO;
                saida_nxt = '1;
            end
        endcase

        if (!ligado) begin
            estado_nxt    = DESLIGADO;
            tabuleiro_nxt = '1;
            acerto_nxt    = '1;
            navios_nxt    = '0;
            acertos_nxt   = '0;
            tent_nxt      = '0;
            salvo_nxt     = 1'b0;
            fim_nxt       = 1'b0;
            led_nxt       = LED_APAGADO;
            saida_nxt     = '1;
`ifdef ATAQUE_REPETIDO_EN
            agua_nxt      = '1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado      <= DESLIGADO;
            tabuleiro   <= '1;
            acerto_q    <= '1;
            navios      <= '0;
            acertos     <= '0;
            tentativas  <= '0;
            jogo_salvo  <= 1'b0;
            fim_de_jogo <= 1'b0;
            ledRGB      <= LED_APAGADO;
            saida       <= '1;
`ifdef ATAQUE_REPETIDO_EN
            agua_q      <= '1;
`endif
        end else begin
            estado      <= estado_nxt;
            tabuleiro   <= tabuleiro_nxt;
            acerto_q    <= acerto_nxt;
            navios      <= navios_nxt;
            acertos     <= acertos_nxt;
            tentativas  <= tent_nxt;
            jogo_salvo  <= salvo_nxt;
            fim_de_jogo <= fim_nxt;
            ledRGB      <= led_nxt;
            saida       <= saida_nxt;
`ifdef ATAQUE_REPETIDO_EN
            agua_q      <= agua_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_controlador_batalha.sv
// Bench for controlador_batalha: directed vector table plus randomized run against a board model.
module tb_controlador_batalha;

    localparam int COL = 5;
    localparam int LIN = 7;
    localparam int N   = COL * LIN;
`ifdef ATAQUE_REPETIDO_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk, rst_n, ligado, modo, salvar_jogo, confirmar_ataque;
    logic [2:0]   ataque_coluna, ataque_linha;
    logic [N-1:0] posicionamento, saida;
    logic [1:0]   ledRGB;
    logic         jogo_salvo, fim_de_jogo;
    logic [5:0]   acertos;
    logic [7:0]   tentativas;

    int checks   = 0;
    int failures = 0;

    controlador_batalha #(.COLUNAS(COL), .LINHAS(LIN), .W_TENT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ligado           (ligado),
        .modo             (modo),
        .salvar_jogo      (salvar_jogo),
        .confirmar_ataque (confirmar_ataque),
        .ataque_coluna    (ataque_coluna),
        .ataque_linha     (ataque_linha),
        .posicionamento   (posicionamento),
        .saida            (saida),
        .ledRGB           (ledRGB),
        .jogo_salvo       (jogo_salvo),
        .fim_de_jogo      (fim_de_jogo),
        .acertos          (acertos),
        .tentativas       (tentativas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic lig, mod, sal, con;
        logic [2:0] col, lin;
        logic [N-1:0] pos;
        logic [N-1:0] e_saida;
        logic [1:0] e_led;
        logic e_salvo, e_fim;
        logic [5:0] e_ac;
        logic [7:0] e_tent;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic l, m, s, c, input logic [2:0] co, li,
                                input logic [N-1:0] p, es, input logic [1:0] el,
                                input logic esv, ef, input logic [5:0] ea, input logic [7:0] et);
        vec_t v;
        v.lig = l; v.mod = m; v.sal = s; v.con = c; v.col = co; v.lin = li; v.pos = p;
        v.e_saida = es; v.e_led = el; v.e_salvo = esv; v.e_fim = ef; v.e_ac = ea; v.e_tent = et;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nome, input logic [N-1:0] es, input logic [1:0] el,
                       input logic esv, ef, input logic [5:0] ea, input logic [7:0] et);
        checks++;
        if (saida !== es || ledRGB !== el || jogo_salvo !== esv || fim_de_jogo !== ef ||
            acertos !== ea || tentativas !== et) begin
            failures++;
            $display("FAIL %s: got saida=%h led=%b salvo=%b fim=%b acertos=%0d tent=%0d, want saida=%h led=%b salvo=%b fim=%b acertos=%0d tent=%0d",
                     nome, saida, ledRGB, jogo_salvo, fim_de_jogo, acertos, tentativas,
                     es, el, esv, ef, ea, et);
        end
    endtask

    // Behavioural model: ship/hit/shot sets per cell and a coarse game phase.
    localparam int F_OFF = 0, F_PLACE = 1, F_ATK = 2, F_END = 3;
    int           m_fase, m_navios, m_ac, m_tent;
    bit           m_salvo, m_fim, prev_s, prev_c;
    bit           navio[N], atingido[N], tentado[N];
    logic [1:0]   m_led;
    logic [N-1:0] m_saida;

    task automatic model_clear();
        m_fase = F_OFF; m_navios = 0; m_ac = 0; m_tent = 0;
        m_salvo = 0; m_fim = 0; m_led = 2'b00; m_saida = '1;
        for (int i = 0; i < N; i++) begin navio[i] = 0; atingido[i] = 0; tentado[i] = 0; end
    endtask

    task automatic model_step(input logic l, m, s, c, input logic [2:0] co, li, input logic [N-1:0] p);
        bit se, ce;
        int cnt, i;
        se = s && !prev_s; ce = c && !prev_c;
        prev_s = s; prev_c = c;
        if (!l) begin
            model_clear();
            return;
        end
        case (m_fase)
            F_OFF: m_fase = F_PLACE;
            F_PLACE: begin
                if (m) m_fase = F_ATK;
                else if (se) begin
                    cnt = 0;
                    for (int k = 0; k < N; k++) if (!p[k]) cnt++;
                    if (cnt > 0) begin
                        for (int k = 0; k < N; k++) begin
                            navio[k] = !p[k]; atingido[k] = 0; tentado[k] = 0;
                        end
                        m_navios = cnt; m_ac = 0; m_tent = 0; m_fim = 0; m_salvo = 1;
                    end
                end
            end
            F_ATK: begin
                if (!m) m_fase = F_PLACE;
                else begin
                    if (ce && m_salvo) begin
                        if (co < 1 || co > COL || li < 1 || li > LIN) m_led = 2'b11;
                        else begin
                            i = (int'(co) - 1) * LIN + int'(li) - 1;
                            if (REP && (atingido[i] || tentado[i])) m_led = 2'b11;
                            else begin
                                if (m_tent < 255) m_tent++;
                                if (navio[i]) begin
                                    m_led = 2'b10;
                                    if (!atingido[i]) begin atingido[i] = 1; m_ac++; end
                                end else begin
                                    m_led = 2'b01;
                                    tentado[i] = 1;
                                end
                            end
                        end
                        if (m_ac == m_navios) m_fim = 1;
                    end
                    if (m_fim) m_fase = F_END;
                end
            end
            default: if (!m) m_fase = F_PLACE;
        endcase
        if (m_fase == F_PLACE) begin m_led = 2'b00; m_saida = p; end
        else if (m_fase == F_END) m_led = 2'b10;
        if (m_fase == F_ATK || m_fase == F_END)
            for (int k = 0; k < N; k++) m_saida[k] = !atingido[k];
    endtask

    initial begin
        logic [N-1:0] ONES, P, H1, Q;
        logic [1:0]   l19;
        logic [7:0]   t19;
        int           ship_idx[4];

        ONES = '1;
        P = ONES; P[0] = 1'b0; P[8] = 1'b0;
        H1 = ONES; H1[0] = 1'b0;
        Q = H1;
        l19 = REP ? 2'b11 : 2'b01;
        t19 = REP ? 8'd1 : 8'd2;

        //          l  m  s  c  col lin pos   saida led salvo fim ac tent
        tab.push_back(mk(1, 0, 0, 0, 0, 0, P,  P,    2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 1, 0, 0, 0, P,  P,    2'b00, 1, 0, 0, 0));
        tab.push_back(mk(1, 0, 1, 0, 0, 0, P,  P,    2'b00, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 1, 1, P,  ONES, 2'b00, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 1, 1, P,  H1,   2'b10, 1, 0, 1, 1));
        tab.push_back(mk(1, 1, 0, 0, 2, 2, P,  H1,   2'b10, 1, 0, 1, 1));
        tab.push_back(mk(1, 1, 0, 1, 2, 2, P,  P,    2'b10, 1, 1, 2, 2));
        tab.push_back(mk(1, 1, 0, 0, 3, 3, P,  P,    2'b10, 1, 1, 2, 2));
        tab.push_back(mk(1, 1, 0, 1, 3, 3, P,  P,    2'b10, 1, 1, 2, 2));
        tab.push_back(mk(1, 0, 0, 0, 3, 3, Q,  Q,    2'b00, 1, 1, 2, 2));
        tab.push_back(mk(1, 0, 1, 0, 3, 3, Q,  Q,    2'b00, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 0, 3, Q,  ONES, 2'b00, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 0, 3, Q,  ONES, 2'b11, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 6, 1, Q,  ONES, 2'b11, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 6, 1, Q,  ONES, 2'b11, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 3, 3, Q,  ONES, 2'b11, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 3, 3, Q,  ONES, 2'b01, 1, 0, 0, 1));
        tab.push_back(mk(1, 1, 0, 0, 3, 3, Q,  ONES, 2'b01, 1, 0, 0, 1));
        tab.push_back(mk(1, 1, 0, 1, 3, 3, Q,  ONES, l19,   1, 0, 0, t19));
        tab.push_back(mk(1, 1, 0, 0, 2, 1, Q,  ONES, l19,   1, 0, 0, t19));
        for (int k = 0; k < 10; k++)
            tab.push_back(mk(1, 1, 0, 1, 2, 1, Q, ONES, 2'b01, 1, 0, 0, t19 + 8'd1));
        tab.push_back(mk(1, 1, 0, 0, 2, 1, Q,    ONES, 2'b01, 1, 0, 0, t19 + 8'd1));
        tab.push_back(mk(0, 1, 0, 1, 1, 1, Q,    ONES, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 1, 1, ONES, ONES, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 1, 0, 1, 1, ONES, ONES, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 0, 1, 1, ONES, ONES, 2'b00, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 1, 1, 1, ONES, ONES, 2'b00, 0, 0, 0, 0));

        // Reset with junk on the inputs
        rst_n = 1'b0; ligado = 1'b1; modo = 1'b1; salvar_jogo = 1'b0; confirmar_ataque = 1'b1;
        ataque_coluna = 3'd1; ataque_linha = 3'd1; posicionamento = P;
        tick();
        cmp("reset0", ONES, 2'b00, 0, 0, 0, 0);
        tick();
        cmp("reset1", ONES, 2'b00, 0, 0, 0, 0);
        ligado = 1'b0; confirmar_ataque = 1'b0;
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            ligado = tab[i].lig; modo = tab[i].mod; salvar_jogo = tab[i].sal;
            confirmar_ataque = tab[i].con; ataque_coluna = tab[i].col;
            ataque_linha = tab[i].lin; posicionamento = tab[i].pos;
            tick();
            cmp($sformatf("vetor%0d", i), tab[i].e_saida, tab[i].e_led, tab[i].e_salvo,
                tab[i].e_fim, tab[i].e_ac, tab[i].e_tent);
        end

        // Randomized run against the model
        rst_n = 1'b0; ligado = 1'b0; salvar_jogo = 1'b0; confirmar_ataque = 1'b0; modo = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear(); prev_s = 0; prev_c = 0;
        ship_idx[0] = 0; ship_idx[1] = 1; ship_idx[2] = 7; ship_idx[3] = 8;
        posicionamento = P;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ligado = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) modo = ~modo;
            salvar_jogo      = ($urandom_range(0, 3) == 0);
            confirmar_ataque = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0) begin
                ataque_coluna = 3'($urandom_range(1, 2));
                ataque_linha  = 3'($urandom_range(1, 2));
            end else begin
                ataque_coluna = 3'($urandom_range(0, 7));
                ataque_linha  = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 39) == 0) begin
                posicionamento = '1;
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 1) == 1) posicionamento[ship_idx[k]] = 1'b0;
            end
            model_step(ligado, modo, salvar_jogo, confirmar_ataque, ataque_coluna,
                       ataque_linha, posicionamento);
            tick();
            cmp($sformatf("aleatorio%0d", cyc), m_saida, m_led, m_salvo, m_fim,
                6'(m_ac), 8'(m_tent));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
